ps2_tx: RTL and testbench

- PS/2 host-to-device transmitter. The opposite direction of the existing PS/2 keyboard receiver (kb_data/kb_done).
- The port controller starts a byte send when the CPU writes keyboard commands through port 0x60 (e.g. 0xED set LEDs, 0xF4 enable, 0xFF reset).
- Drives PS2_CLK/PS2_DAT open-collector: the top level ties each pin to 1'bZ, or to 0 when the matching *_oe is high.
- Reports completion and device ACK status to the port controller.

---
 rtl/ps2_tx.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. It inhibits the bus, asserts request-to-send, then shifts a
// byte out on device-generated clocks and reports whether the device returned an ACK.
module ps2_tx #(
    parameter int unsigned INHIBIT_CYC = 2500,
    parameter int unsigned RTS_CYC     = 25,
    parameter int unsigned TIMEOUT_CYC = 375000,
    parameter int unsigned FILTER      = 4
) (
    input  logic       clock_25,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit
);

    localparam int unsigned TW      = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CYC_MAX = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
    localparam int unsigned CW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int unsigned FW      = (FILTER > 1) ? $clog2(FILTER + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYC - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StWaitIdle,
        StFin
    } state_e;

    // Input path: synchronisers on both pins, glitch filter on the clock only.
    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          clk_filt_q, clk_filt_prev_q;
    logic [FW-1:0] flt_cnt_q;
    logic          clk_fall;

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            clk_s1_q        <= 1'b1;
            clk_s2_q        <= 1'b1;
            dat_s1_q        <= 1'b1;
            dat_s2_q        <= 1'b1;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
            flt_cnt_q       <= '0;
        end else begin
            clk_s1_q        <= ps2_clk_i;
            clk_s2_q        <= clk_s1_q;
            dat_s1_q        <= ps2_dat_i;
            dat_s2_q        <= dat_s1_q;
            clk_filt_prev_q <= clk_filt_q;
            if (clk_s2_q == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                clk_filt_q <= clk_s2_q;
                flt_cnt_q  <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end
    end

    assign clk_fall = clk_filt_prev_q & ~clk_filt_q;

    // Transfer FSM.
    state_e        state_q, state_d;
    logic [9:0]    sh_q, sh_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [TW-1:0] tmo_inc;
    logic          tmo_hit;
    logic          ack_q, ack_d;
    logic          error_q, error_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    assign tmo_inc = tmo_q + TW'(1);
    assign tmo_hit = (tmo_inc == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        cyc_d     = cyc_q;
        tmo_d     = tmo_q;
        ack_d     = ack_q;
        error_d   = error_q;
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sh_d     = {1'b1, ~^data, data};
                    error_d  = 1'b0;
                    cyc_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                clk_oe_d = 1'b1;
                if (cyc_q == INH_LAST) begin
                    cyc_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = StRts;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StRts: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b1;
                if (cyc_q == RTS_LAST) begin
                    // Clock released; data stays low as the start bit.
                    clk_oe_d  = 1'b0;
                    cyc_d     = '0;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                    state_d   = StSend;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StSend: begin
                dat_oe_d = dat_oe_q;
                tmo_d    = tmo_inc;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd10) begin
                        dat_oe_d = ~sh_q[bit_cnt_q];
                    end else begin
                        ack_d    = ~dat_s2_q;
                        dat_oe_d = 1'b0;
                        state_d  = StWaitIdle;
                    end
                end
                if (tmo_hit) begin
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = StFin;
                end
            end
            StWaitIdle: begin
                tmo_d = tmo_inc;
                if (clk_filt_q && dat_s2_q) begin
                    error_d = ~ack_q;
                    state_d = StFin;
                end
                if (tmo_hit) begin
                    error_d = 1'b1;
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_d = (state_d inside {StInhibit, StRts, StSend, StWaitIdle});
    assign done_d = (state_d == StFin);

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            cyc_q     <= '0;
            tmo_q     <= '0;
            ack_q     <= 1'b0;
            error_q   <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_q     <= cyc_d;
            tmo_q     <= tmo_d;
            ack_q     <= ack_d;
            error_q   <= error_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign rx_inhibit = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the host and a scoreboard checks
// the sampled frame bits and the done/error report. Timeout is shortened to keep runs quick.
`timescale 1ns/1ps
module tb_ps2_tx;

    localparam int unsigned INHIBIT_CYC = 2500;
    localparam int unsigned RTS_CYC     = 25;
    localparam int unsigned TIMEOUT_CYC = 4000;
    localparam int unsigned FILTER      = 4;
    localparam int          HALF        = 50;

    logic       clock_25 = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] data;
    logic       busy, done, error;
    logic       ps2_clk_oe, ps2_dat_oe, rx_inhibit;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       glitch  = 1'b0;

    // Open-collector bus: low if either side pulls.
    assign ps2_clk_i = dev_clk & ~ps2_clk_oe & ~glitch;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    ps2_tx #(
        .INHIBIT_CYC(INHIBIT_CYC),
        .RTS_CYC    (RTS_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FILTER     (FILTER)
    ) dut (
        .clock_25  (clock_25),
        .reset_n   (reset_n),
        .start     (start),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .rx_inhibit(rx_inhibit)
    );

    always #20 clock_25 = ~clock_25;

    typedef struct {
        logic [9:0] frame;
        logic       err;
        bit         chk_bits;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [9:0] dev_bits;

    always @(posedge clock_25) if (done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_25);
    endtask

    task automatic issue(input logic [7:0] d, input bit push, input bit exp_err, input bit chk);
        exp_t e;
        data  = d;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        if (push) begin
            e.frame    = {1'b1, ~^d, d};
            e.err      = exp_err;
            e.chk_bits = chk;
            sb.push_back(e);
        end
    endtask

    // Device model: waits out inhibit/RTS, then generates 11 clocks, sampling on rising edges.
    task automatic device(input bit give_ack, input int glitch_at, input int abort_at);
        int t;
        int low_cyc;
        dev_bits = '0;
        t = 0;
        while (ps2_clk_i !== 1'b0 && t < 100) begin cyc(1); t++; end
        check_eq("inhibit_seen", 32'(ps2_clk_i), 32'd0);
        low_cyc = 0;
        while (ps2_clk_i === 1'b0 && low_cyc < int'(INHIBIT_CYC + RTS_CYC) + 100) begin
            cyc(1);
            low_cyc++;
        end
        check_eq("inhibit_len_ok", 32'(low_cyc >= int'(INHIBIT_CYC)), 32'd1);
        check_eq("start_bit", 32'(ps2_dat_i), 32'd0);
        for (int i = 0; i < 11; i++) begin
            if (i == glitch_at) begin
                cyc(20);
                glitch = 1'b1;
                cyc(1);
                glitch = 1'b0;
                cyc(HALF - 21);
            end else begin
                cyc(HALF);
            end
            dev_clk = 1'b0;
            if (i == abort_at) begin
                cyc(10);
                reset_n = 1'b0;
                cyc(1);
                check_eq("rst_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_done", 32'(done), 32'd0);
                reset_n = 1'b1;
                dev_clk = 1'b1;
                return;
            end
            cyc(HALF);
            dev_clk = 1'b1;
            if (i < 10) dev_bits[i] = ps2_dat_i;
            if (i == 9 && give_ack) dev_dat = 1'b0;
            if (i == 10) dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag);
        int   t;
        exp_t e;
        e.frame    = '0;
        e.err      = 1'b0;
        e.chk_bits = 1'b0;
        t = 0;
        while (done !== 1'b1 && t < int'(TIMEOUT_CYC) + 200) begin cyc(1); t++; end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq({tag, "_sb_has_entry"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq({tag, "_error"}, 32'(error), 32'(e.err));
                if (e.chk_bits) check_eq({tag, "_frame"}, 32'(dev_bits), 32'(e.frame));
            end
            check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            cyc(1);
            check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check_eq({tag, "_error_held"}, 32'(error), 32'(e.err));
            check_eq({tag, "_lines_released"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, %0d checks made", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int n0;
        reset_n = 1'b0;
        start   = 1'b0;
        data    = 8'h00;
        cyc(3);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_error", 32'(error), 32'd0);
        check_eq("reset_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        reset_n = 1'b1;
        cyc(2);

        // 0xED with ACK: LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1.
        issue(8'hED, 1'b1, 1'b0, 1'b1);
        check_eq("ed_busy", 32'(busy), 32'd1);
        check_eq("ed_rx_inhibit", 32'(rx_inhibit), 32'd1);
        device(1'b1, -1, -1);
        wait_done("ed");

        issue(8'h01, 1'b1, 1'b0, 1'b1);
        device(1'b1, -1, -1);
        wait_done("x01");

        issue(8'hFF, 1'b1, 1'b0, 1'b1);
        device(1'b1, -1, -1);
        wait_done("xff");

        // Device never ACKs.
        issue(8'h3C, 1'b1, 1'b1, 1'b1);
        device(1'b0, -1, -1);
        wait_done("noack");

        // Second start during SEND must be ignored.
        n0 = done_cnt;
        issue(8'hC3, 1'b1, 1'b0, 1'b1);
        fork
            device(1'b1, -1, -1);
            begin
                cyc(2700);
                data  = 8'h55;
                start = 1'b1;
                cyc(1);
                start = 1'b0;
                check_eq("restart_busy", 32'(busy), 32'd1);
            end
        join
        wait_done("restart");
        cyc(50);
        check_eq("restart_done_count", 32'(done_cnt - n0), 32'd1);

        // Reset during data bit 4, then a clean frame.
        n0 = done_cnt;
        issue(8'hA5, 1'b0, 1'b0, 1'b0);
        device(1'b1, -1, 4);
        cyc(20);
        check_eq("rst_no_done", 32'(done_cnt - n0), 32'd0);
        issue(8'h96, 1'b1, 1'b0, 1'b1);
        device(1'b1, -1, -1);
        wait_done("post_rst");

        // One-cycle clock glitch while high in SEND.
        issue(8'h3A, 1'b1, 1'b0, 1'b1);
        device(1'b1, 3, -1);
        wait_done("glitch");

        // No device clocking: timeout measured from clock release.
        issue(8'hF4, 1'b1, 1'b1, 1'b0);
        t = 0;
        while (ps2_clk_oe !== 1'b1 && t < 50) begin cyc(1); t++; end
        t = 0;
        while (ps2_clk_oe === 1'b1 && t < int'(INHIBIT_CYC + RTS_CYC) + 100) begin
            cyc(1);
            t++;
        end
        check_eq("tmo_release", 32'(ps2_clk_oe), 32'd0);
        t = 0;
        while (done !== 1'b1 && t < int'(TIMEOUT_CYC) + 100) begin cyc(1); t++; end
        check_eq("tmo_window", 32'(t >= int'(TIMEOUT_CYC) - 1 && t <= int'(TIMEOUT_CYC) + 1),
                 32'd1);
        wait_done("tmo");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
